// File: rtl/morse_keyer.sv
// morse_keyer: turns dot/dash/letter-gap/word-gap symbol codes into a timed Morse key line.
// Every output is registered and is computed from the next state, so cycle 1 of a symbol begins at the accepting edge.
module morse_keyer #(
    parameter int UNIT_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sym_valid,
    input  logic [1:0] i_sym_code,
    input  logic       i_abort,
    output logic       o_sym_ready,
    output logic       o_key,
    output logic       o_busy,
    output logic       o_done
);
    localparam int CW = $clog2(6 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] C_DOT  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] C_DASH = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] C_LGAP = CW'(2 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] C_WGAP = CW'(6 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE} state_t;

    state_t        r_state, w_nxt_state;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    logic          w_accept, w_nxt_last;

    // r_cnt holds the cycles left in the current phase after this one; the
    // trailing element gap of a dot or dash always lasts one unit.
    always_comb begin
        w_accept    = i_sym_valid & o_sym_ready;
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        if (i_abort) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
        end else if (w_accept) begin
            w_nxt_state = i_sym_code[1] ? S_SPACE : S_MARK;
            w_nxt_cnt   = i_sym_code[1] ? (i_sym_code[0] ? C_WGAP : C_LGAP)
                                        : (i_sym_code[0] ? C_DASH : C_DOT);
        end else if (r_state != S_IDLE) begin
            if (r_cnt != '0) begin
                w_nxt_cnt = r_cnt - CW'(1);
            end else if (r_state == S_MARK) begin
                w_nxt_state = S_SPACE;
                w_nxt_cnt   = C_DOT;
            end else begin
                w_nxt_state = S_IDLE;
            end
        end
        w_nxt_last = (w_nxt_state == S_SPACE) && (w_nxt_cnt == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            o_key       <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_sym_ready <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            o_key       <= w_nxt_state == S_MARK;
            o_busy      <= w_nxt_state != S_IDLE;
            o_done      <= w_nxt_last;
            o_sym_ready <= (w_nxt_state == S_IDLE) || w_nxt_last;
        end
    end
endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: drives UNIT_CYCLES=2 and =1 keyers with one shared stimulus stream
// and compares each against a per-symbol key-profile model.
module tb_morse_keyer;
    localparam logic [1:0] DOT = 2'd0, DASH = 2'd1, LGAP = 2'd2, WGAP = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n, valid, abort;
    logic [1:0] code;
    logic [1:0] key, busy, done, rdy;

    int  n_tests = 0, n_fail = 0;
    int  uu[2] = '{2, 1};
    int  len[2], pos[2];
    bit  prof[2][16];
    bit  acc[2];
    bit  started;

    always #5 clk = ~clk;

    morse_keyer #(.UNIT_CYCLES(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sym_valid(valid), .i_sym_code(code), .i_abort(abort),
        .o_sym_ready(rdy[0]), .o_key(key[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    morse_keyer #(.UNIT_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sym_valid(valid), .i_sym_code(code), .i_abort(abort),
        .o_sym_ready(rdy[1]), .o_key(key[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit exp_rdy(int g);
        return started && (len[g] == 0 || pos[g] == len[g]);
    endfunction

    task automatic compare_outputs();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("u%0d key", uu[g]), 32'(key[g]), 32'(len[g] > 0 ? prof[g][pos[g]-1] : 1'b0));
            check($sformatf("u%0d busy", uu[g]), 32'(busy[g]), 32'(len[g] > 0));
            check($sformatf("u%0d done", uu[g]), 32'(done[g]), 32'(len[g] > 0 && pos[g] == len[g]));
            check($sformatf("u%0d ready", uu[g]), 32'(rdy[g]), 32'(exp_rdy(g)));
        end
    endtask

    // One clock: decide acceptance from the model's own ready, advance one cycle, compare.
    task automatic step();
        for (int g = 0; g < 2; g++) acc[g] = rst_n && valid && exp_rdy(g);
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n || abort) begin
                len[g] = 0;
            end else if (acc[g]) begin
                int u = uu[g];
                int m = code[1] ? 0 : (code[0] ? 3 * u : u);
                int n = code[1] ? (code[0] ? 6 * u : 2 * u) : m + u;
                for (int i = 0; i < n; i++) prof[g][i] = (i < m);
                len[g] = n;
                pos[g] = 1;
            end else if (len[g] > 0) begin
                pos[g]++;
                if (pos[g] > len[g]) len[g] = 0;
            end
        end
        started = rst_n;
        compare_outputs();
    endtask

    task automatic drive(input bit v, input logic [1:0] c, input bit a);
        valid = v;
        code  = c;
        abort = a;
    endtask

    task automatic send(input logic [1:0] c);
        int n = 0;
        drive(1'b1, c, 1'b0);
        do begin
            step();
            n++;
        end while (!acc[0] && n < 50);
        if (!acc[0]) check("send timeout", 32'd0, 32'd1);
        valid = 1'b0;
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        len     = '{0, 0};
        started = 1'b0;
        compare_outputs();
    endtask

    initial begin
        drive(1'b0, DOT, 1'b0);
        rst_n   = 1'b0;
        started = 1'b0;
        len     = '{0, 0};
        pos     = '{0, 0};
        #2 compare_outputs();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        // single dot
        send(DOT);
        repeat (6) step();
        // dot then dash, valid held
        drive(1'b1, DOT, 1'b0);
        step();
        drive(1'b1, DASH, 1'b0);
        repeat (11) step();
        valid = 1'b0;
        repeat (12) step();
        // letter and word gaps
        send(DOT);
        send(LGAP);
        send(DOT);
        send(WGAP);
        repeat (16) step();
        // abort in cycle 3 of a dash, with a dot offered at the same edge
        send(DASH);
        step();
        drive(1'b1, DOT, 1'b1);
        step();
        drive(1'b0, DOT, 1'b0);
        repeat (4) step();
        // async reset between edges in the middle of a dash
        send(DASH);
        step();
        #2 reset_now();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        send(DOT);
        repeat (6) step();
        // random traffic with code churn while busy, occasional abort and reset
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 6, 2'($urandom), $urandom_range(0, 49) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_now();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        drive(1'b0, DOT, 1'b0);
        repeat (20) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
